// File: rtl/exp_pkg.sv
// Shared definitions for the exponential datapath: widths, Q-format constants,
// saturation value and the reconstruction FSM state encoding.
package exp_pkg;

  localparam int FRAC_W_DEF  = 15;
  localparam int OUT_W_DEF   = 32;
  localparam int Q_FRAC_BITS = 14;
  localparam int I_W         = 5;

  localparam logic [OUT_W_DEF-1:0] SAT_VALUE = {OUT_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } exp_state_e;

  // Fraction-only operands carry no power-of-two scaling.
  function automatic logic [I_W-1:0] shift_amount(input logic [I_W-1:0] i,
                                                  input logic           int_or_fra);
    if (int_or_fra) begin
      shift_amount = i;
    end else begin
      shift_amount = {I_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/exp_sat_shl1.sv
// Combinational one-bit left shift that clamps to all ones when the MSB would
// be lost; ovf flags that clamp.
module exp_sat_shl1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] data,
  output logic [W-1:0] shifted,
  output logic         ovf
);

  // Saturating shift: an all-ones word stays all ones on every later shift.
  always_comb begin
    shifted = {data[W-2:0], 1'b0};
    ovf     = 1'b0;
    if (data[W-1]) begin
      shifted = {W{1'b1}};
      ovf     = 1'b1;
    end else begin
      ovf     = 1'b0;
    end
  end

endmodule

// File: rtl/exp_reconstruct.sv
// Reconstructs e^x = 2^k * e^r by shifting the e^r mantissa left one bit per
// cycle, saturating to all ones on overflow, with valid/ready on both sides.
module exp_reconstruct
  import exp_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [I_W-1:0]    i,
  input  logic              int_or_fra,
  input  logic [FRAC_W-1:0] frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  result,
  output logic              sat
);

  exp_state_e         state_r, state_s;
  logic [OUT_W-1:0]   acc_r, acc_s;
  logic [I_W-1:0]     count_r, count_s;
  logic               sat_flag_r, sat_flag_s;
  logic [OUT_W-1:0]   result_r, result_s;
  logic               sat_r, sat_s;
  logic               in_ready_r, out_valid_r;

  logic [OUT_W-1:0]   frac_ext_s;
  logic [I_W-1:0]     k_s;
  logic [OUT_W-1:0]   shl_s;
  logic               shl_ovf_s;

  assign frac_ext_s = {{(OUT_W-FRAC_W){1'b0}}, frac};
  assign k_s        = shift_amount(i, int_or_fra);

  exp_sat_shl1 #(
    .W (OUT_W)
  ) u_shl (
    .data    (acc_r),
    .shifted (shl_s),
    .ovf     (shl_ovf_s)
  );

  // Next-state and datapath update; result/sat only change when HOLD is entered.
  always_comb begin
    state_s    = state_r;
    acc_s      = acc_r;
    count_s    = count_r;
    sat_flag_s = sat_flag_r;
    result_s   = result_r;
    sat_s      = sat_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          acc_s      = frac_ext_s;
          count_s    = k_s;
          sat_flag_s = 1'b0;
          if (k_s != {I_W{1'b0}}) begin
            state_s = SHIFT;
          end else begin
            state_s  = HOLD;
            result_s = frac_ext_s;
            sat_s    = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        acc_s      = shl_s;
        count_s    = count_r - {{(I_W-1){1'b0}}, 1'b1};
        sat_flag_s = sat_flag_r | shl_ovf_s;
        // Leaving on the edge where the count reaches zero.
        if (count_r <= {{(I_W-1){1'b0}}, 1'b1}) begin
          state_s  = HOLD;
          count_s  = {I_W{1'b0}};
          result_s = shl_s;
          sat_s    = sat_flag_r | shl_ovf_s;
        end else begin
          state_s = SHIFT;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {OUT_W{1'b0}};
      count_r     <= {I_W{1'b0}};
      sat_flag_r  <= 1'b0;
      result_r    <= {OUT_W{1'b0}};
      sat_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      count_r     <= count_s;
      sat_flag_r  <= sat_flag_s;
      result_r    <= result_s;
      sat_r       <= sat_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == HOLD);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign sat       = sat_r;

endmodule

// File: doc/exp_reconstruct.md
EXP_RECONSTRUCT -- requirements
Module: exp_reconstruct

Interface
REQ-001 Parameters SHALL be: FRAC_W, default 15, width of the fraction mantissa (unsigned Q1.14, value in [1.0, 2.0)); OUT_W, default 32, width of the result (unsigned Q18.14).
REQ-002 Ports SHALL be, in this order:
- clk  input  1  single clock for the whole block.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream presents an operand.
- in_ready  output  1  block can accept an operand.
- i  input  5  power-of-two exponent from range reduction.
- int_or_fra  input  1  1 = integer part present (apply i); 0 = fraction-only input (force shift 0).
- frac  input  FRAC_W  e^r mantissa.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- result  output  OUT_W  2^k * frac, saturated.
- sat  output  1  result was saturated.

Function
REQ-003 The operation SHALL compute result = frac << k, where k = int_or_fra ? i : 0, zero-extended to OUT_W.
REQ-004 The FSM SHALL have three states: IDLE, SHIFT and HOLD.
REQ-005 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-006 An operand SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-007 On acceptance: accumulator <= zero-extended frac; count <= k; sat flag <= 0; next state is SHIFT if k != 0, otherwise HOLD.
REQ-008 Each cycle in SHIFT: accumulator SHALL shift left by 1 and count SHALL decrement by 1.
REQ-009 In SHIFT, if bit OUT_W-1 is 1 before a shift, the sat flag SHALL be set (sticky) and the accumulator forced to all ones; it SHALL stay all ones for the remaining shifts.
REQ-010 The transition SHIFT -> HOLD SHALL occur on the edge where count reaches 0.
REQ-011 Latency: out_valid SHALL rise exactly k+1 cycles after the acceptance edge.
REQ-012 In HOLD, out_valid SHALL be 1, and result and sat SHALL be stable until out_valid && out_ready.
REQ-013 On the handshake edge (out_valid && out_ready) the state SHALL return to IDLE; no operand is accepted in that same cycle, so throughput is one operand per k+2 cycles.
REQ-014 Operand inputs SHALL be sampled only at acceptance; changes afterwards SHALL have no effect.
REQ-015 Outside HOLD, out_valid SHALL be 0; result and sat SHALL keep their last values.
REQ-016 i values up to 31 SHALL be legal; any overflow saturates per REQ-009.
REQ-017 A frac value below 0x4000 SHALL NOT be checked; it is processed arithmetically as given.

Reset
REQ-018 When rst_n is low, the block SHALL asynchronously force: state IDLE, in_ready 1, out_valid 0, result 0, sat 0, count 0.
REQ-019 Reset asserted mid-SHIFT or mid-HOLD SHALL abort the operation; the result SHALL be discarded and no out_valid pulse shall follow.
REQ-020 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-021 A shared package exp_pkg SHALL hold the FRAC_W/OUT_W defaults, the Q-format fraction-bit constant (14), the saturation value (all ones) and the FSM state enum; the range-reduction block uses the same package.
REQ-022 One sub-module, exp_sat_shl1 (combinational 1-bit saturating left shift of an OUT_W word, with overflow output), SHALL be instantiated by the block.

Verification
REQ-023 frac=0x4000, int_or_fra=0, i=7 -> result=0x00004000, sat=0, out_valid 1 cycle after acceptance.
REQ-024 frac=0x5A82, int_or_fra=1, i=3 -> result=0x0002D410, sat=0, out_valid 4 cycles after acceptance.
REQ-025 frac=0x7FFF, int_or_fra=1: i=17 -> result=0xFFFE0000, sat=0; i=18 -> result=0xFFFFFFFF, sat=1; i=31 -> result=0xFFFFFFFF, sat=1.
REQ-026 Hold out_ready=0 for 10 cycles in HOLD -> out_valid, result and sat stable, in_ready=0; then out_ready=1 -> IDLE on the next edge and in_ready=1.
REQ-027 Assert rst_n=0 two cycles into a k=5 operation -> all outputs at reset values, no out_valid; a new operand after release -> correct result.
REQ-028 Back-to-back random operands (i 0..23, frac 0x4000..0x7FFF, int_or_fra random) with random out_ready -> every result matches the reference model, and no operand is lost or duplicated.
